// File: rtl/saph_fpu_arbiter_if.sv
// saph_fpi: request/result link between a shader core and an FPU.
// LATENCY advertises the FPU's issue-to-result depth to whatever connects to it.
interface saph_fpi #(
   parameter int LATENCY = 2
);
   logic        d_trig;
   logic [31:0] d_lhs;
   logic [31:0] d_rhs;
   logic [1:0]  d_mode;
   logic        d_ready;
   logic        q_trig;
   logic [31:0] q_res;
   logic        has_modes;

   // FPU: the side that executes operations (the arbiter presents this face to each core).
   modport FPU (
      input  d_trig, d_lhs, d_rhs, d_mode,
      output d_ready, q_trig, q_res, has_modes
   );

   // GPU: the side that issues operations (the arbiter presents this face to the shared FPU).
   modport GPU (
      output d_trig, d_lhs, d_rhs, d_mode,
      input  d_ready, q_trig, q_res, has_modes
   );
endinterface

// File: rtl/saph_fpu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FPU among GPUS cores, with owner tracking.
// Optional per-port grant counters when SAPH_FPU_ARB_STATS_EN is defined.
module saph_fpu_arbiter #(
   parameter int GPUS    = 4,
   parameter int LATENCY = 2
) (
   input  logic       clk,
   input  logic       rst,
   saph_fpi.FPU       gpu [GPUS],
   saph_fpi.GPU       fpu,
   output logic       err
`ifdef SAPH_FPU_ARB_STATS_EN
   ,
   output logic [15:0] stat_grants [GPUS]
`endif
);

   localparam int IW = (GPUS > 1) ? $clog2(GPUS) : 1;

   if (GPUS < 1) begin : g_gpus_chk
      $error("saph_fpu_arbiter: GPUS must be >= 1");
   end
   if (LATENCY != fpu.LATENCY) begin : g_lat_chk
      $error("saph_fpu_arbiter: LATENCY does not match fpu.LATENCY");
   end

   logic [GPUS-1:0] w_req;
   logic [31:0]     w_lhs  [GPUS];
   logic [31:0]     w_rhs  [GPUS];
   logic [1:0]      w_mode [GPUS];

   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   w_gnt;
   logic            w_any;
   logic            w_grant;
   int              w_idx;

   logic            w_tail_vld;
   logic            w_tail_kill;
   logic [IW-1:0]   w_tail_id;

   for (genvar i = 0; i < GPUS; i++) begin : g_port
      assign w_req[i]  = gpu[i].d_trig;
      assign w_lhs[i]  = gpu[i].d_lhs;
      assign w_rhs[i]  = gpu[i].d_rhs;
      assign w_mode[i] = gpu[i].d_mode;

      assign gpu[i].d_ready   = w_grant & (w_gnt == IW'(i));
      assign gpu[i].q_trig    = ~rst & fpu.q_trig & w_tail_vld & (w_tail_id == IW'(i));
      assign gpu[i].q_res     = fpu.q_res;
      assign gpu[i].has_modes = fpu.has_modes;
   end

   // NOTE: every variable gets a default before the search loop so no latch is inferred.
   always_comb begin
      w_any = 1'b0;
      w_gnt = '0;
      w_idx = 0;
      for (int k = 1; k <= GPUS; k++) begin
         w_idx = (int'(r_ptr) + k) % GPUS;
         if (!w_any && w_req[w_idx]) begin
            w_any = 1'b1;
            w_gnt = IW'(w_idx);
         end
      end
   end

   // Requests are ignored during rst so the FPU never starts an op no core saw accepted.
   assign w_grant     = w_any & fpu.d_ready & ~rst;
   assign fpu.d_trig  = w_grant;
   assign fpu.d_lhs   = w_grant ? w_lhs[w_gnt]  : 32'd0;
   assign fpu.d_rhs   = w_grant ? w_rhs[w_gnt]  : 32'd0;
   assign fpu.d_mode  = w_grant ? w_mode[w_gnt] : 2'd0;

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= IW'(GPUS - 1);
      end else if (w_grant) begin
         r_ptr <= w_gnt;
      end
   end

   if (LATENCY == 0) begin : g_lat0
      assign w_tail_vld  = w_grant;
      assign w_tail_kill = 1'b0;
      assign w_tail_id   = w_gnt;
   end else begin : g_pipe
      logic [LATENCY-1:0] r_vld;
      logic [LATENCY-1:0] r_kill;
      logic [IW-1:0]      r_id [LATENCY];

      // r_kill marks slots whose tag was discarded by rst, so their late results are
      // dropped quietly instead of being reported as orphans.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_vld     <= '0;
            r_kill[0] <= 1'b0;
            for (int s = 1; s < LATENCY; s++) begin
               r_kill[s] <= r_vld[s-1] | r_kill[s-1];
            end
         end else begin
            r_vld[0]  <= w_grant;
            r_kill[0] <= 1'b0;
            for (int s = 1; s < LATENCY; s++) begin
               r_vld[s]  <= r_vld[s-1];
               r_kill[s] <= r_kill[s-1];
            end
         end
      end

      // NOTE: owner ids are qualified by r_vld, so they carry no reset.
      always_ff @(posedge clk) begin
         r_id[0] <= w_gnt;
         for (int s = 1; s < LATENCY; s++) begin
            r_id[s] <= r_id[s-1];
         end
      end

      assign w_tail_vld  = r_vld[LATENCY-1];
      assign w_tail_kill = r_kill[LATENCY-1];
      assign w_tail_id   = r_id[LATENCY-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (fpu.q_trig && !w_tail_vld && !w_tail_kill) begin
         err <= 1'b1;
      end
   end

`ifdef SAPH_FPU_ARB_STATS_EN
   logic [15:0] r_stat [GPUS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < GPUS; i++) begin
         if (rst) begin
            r_stat[i] <= 16'd0;
         end else if (w_grant && (w_gnt == IW'(i)) && (r_stat[i] != 16'hFFFF)) begin
            r_stat[i] <= r_stat[i] + 16'd1;
         end
      end
   end

   assign stat_grants = r_stat;
`endif

endmodule
